// File: rtl/pulse_voice_pwm_pkg.sv
// Shared definitions for the pulse-voice audio stage: duty codes, the
// duty-to-threshold mapping and the PWM top value used after reset.
package audio_pkg;

    localparam int PHASE_W_DEF = 32;
    localparam int ENV_W_DEF   = 9;
    localparam int TOP_W_DEF   = 8;

    localparam logic [7:0] TOP_RESET = 8'hff;

    typedef enum logic [1:0] {
        DUTY_12 = 2'd0,
        DUTY_25 = 2'd1,
        DUTY_50 = 2'd2,
        DUTY_75 = 2'd3
    } duty_e;

    // Threshold in eighths of a cycle: the square is high while the top
    // three phase bits are below this value.
    function automatic logic [2:0] duty_thr(input duty_e duty);
        case (duty)
            DUTY_12: return 3'd1;
            DUTY_25: return 3'd2;
            DUTY_50: return 3'd4;
            default: return 3'd6;
        endcase
    endfunction

endpackage

// File: rtl/pulse_voice_pwm_if.sv
// Channel bundle between the note sequencer (master) and the PWM output
// stage (slave).
interface pulse_voice_pwm_if
    import audio_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int ENV_W   = 9,
    parameter int TOP_W   = 8
);

    logic [TOP_W-1:0]   i_top;
    logic               i_top_valid;
    logic [PHASE_W-1:0] i_phase_delta;
    logic [ENV_W-1:0]   i_envelope;
    duty_e              i_duty;
    logic               o_pwm;
    logic               o_period_stb;
    logic [ENV_W-1:0]   o_level;

    modport master (
        output i_top, i_top_valid, i_phase_delta, i_envelope, i_duty,
        input  o_pwm, o_period_stb, o_level
    );

    modport slave (
        input  i_top, i_top_valid, i_phase_delta, i_envelope, i_duty,
        output o_pwm, o_period_stb, o_level
    );

endinterface

// File: rtl/pulse_voice_pwm_counter.sv
// PWM period counter with a shadowed top: a requested top is held pending
// and only takes effect at the counter wrap, so a period is never cut short.
module pwm_period_counter
    import audio_pkg::*;
#(
    parameter int TOP_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [TOP_W-1:0] i_top,
    input  logic             i_top_valid,
    output logic [TOP_W-1:0] o_cnt,
    output logic [TOP_W-1:0] o_top,
    output logic             o_wrap
);

    localparam logic [TOP_W-1:0] TOP_INIT = (TOP_W == 8) ? TOP_W'(TOP_RESET) : '1;

    logic [TOP_W-1:0] cnt_q, cnt_d;
    logic [TOP_W-1:0] top_q, top_d;
    logic [TOP_W-1:0] pend_top_q, pend_top_d;
    logic             pend_valid_q, pend_valid_d;
    logic             wrap;

    assign wrap = (cnt_q == top_q);

    always_comb begin
        cnt_d        = cnt_q + TOP_W'(1);
        top_d        = top_q;
        pend_top_d   = pend_top_q;
        pend_valid_d = pend_valid_q;
        if (wrap) begin
            cnt_d        = '0;
            pend_valid_d = 1'b0;
            // A request arriving on the wrap cycle itself is newer than the shadow.
            if (i_top_valid) begin
                top_d = i_top;
            end else if (pend_valid_q) begin
                top_d = pend_top_q;
            end
        end else if (i_top_valid) begin
            pend_top_d   = i_top;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q        <= '0;
            top_q        <= TOP_INIT;
            pend_top_q   <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            top_q        <= top_d;
            pend_top_q   <= pend_top_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign o_cnt  = cnt_q;
    assign o_top  = top_q;
    assign o_wrap = wrap;

endmodule

// File: rtl/pulse_voice_pwm.sv
// Per-channel pulse-wave voice: a phase accumulator makes a duty-selectable
// square, which is scaled by the envelope and rendered as 1-bit PWM.
module pulse_voice_pwm
    import audio_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int ENV_W   = 9,
    parameter int TOP_W   = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    pulse_voice_pwm_if.slave   bus
);

    localparam int CMP_W = (ENV_W > TOP_W) ? ENV_W : TOP_W + 1;

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [ENV_W-1:0]   level_reg_q, level_reg_d;
    logic               pwm_q, pwm_d;
    logic [TOP_W-1:0]   cnt;
    logic [TOP_W-1:0]   top;
    logic               wrap;
    logic               square;
    logic [ENV_W-1:0]   level;

    pwm_period_counter #(
        .TOP_W (TOP_W)
    ) u_counter (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_top       (bus.i_top),
        .i_top_valid (bus.i_top_valid),
        .o_cnt       (cnt),
        .o_top       (top),
        .o_wrap      (wrap)
    );

    always_comb begin
        phase_d     = phase_q + bus.i_phase_delta;
        square      = (phase_q[PHASE_W-1 -: 3] < duty_thr(bus.i_duty));
        level       = (square && (bus.i_phase_delta != '0)) ? bus.i_envelope : '0;
        level_reg_d = wrap ? level : level_reg_q;
        // A level beyond the period length keeps the output high for the whole period.
        pwm_d       = (CMP_W'(level_reg_q) > CMP_W'(top)) ||
                      (CMP_W'(cnt) < CMP_W'(level_reg_q));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            phase_q     <= '0;
            level_reg_q <= '0;
            pwm_q       <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            level_reg_q <= level_reg_d;
            pwm_q       <= pwm_d;
        end
    end

    assign bus.o_pwm        = pwm_q;
    assign bus.o_period_stb = wrap & ~i_rst;
    assign bus.o_level      = level_reg_q;

endmodule

// File: tb/tb_pulse_voice_pwm.sv
// Bench for pulse_voice_pwm: each PWM period is measured (length between
// strobes, count of high output cycles) and checked against a scoreboard.
module tb_pulse_voice_pwm;
    import audio_pkg::*;

    localparam int PHASE_W = 32;
    localparam int ENV_W   = 9;
    localparam int TOP_W   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pulse_voice_pwm_if #(.PHASE_W(PHASE_W), .ENV_W(ENV_W), .TOP_W(TOP_W)) bus ();

    pulse_voice_pwm #(.PHASE_W(PHASE_W), .ENV_W(ENV_W), .TOP_W(TOP_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [TOP_W-1:0]   top;
        logic [PHASE_W-1:0] delta;
        logic [ENV_W-1:0]   env;
        logic [1:0]         duty;
        int                 len;
        int                 hi2;
        int                 hi3;
        int                 lvl2;
    } vec_t;

    typedef struct {
        int len;
        int hi;
    } exp_t;

    exp_t  sb_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    string cur_name = "init";

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s/%s: got %0d, expected %0d", cur_name, name, act, req);
        end
    endtask

    // Period monitor: the output lags cnt by one clock, so a period's high
    // count covers the cycle after its strobe and excludes the one after the previous strobe.
    int   mon_t = 0;
    int   mon_last = -1;
    int   mon_acc = 0;
    logic mon_prev_stb = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            mon_t        = 0;
            mon_last     = -1;
            mon_acc      = 0;
            mon_prev_stb = 1'b0;
        end else begin
            mon_acc += int'(bus.o_pwm);
            if (mon_prev_stb) begin
                if (sb_q.size() > 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("period_len", mon_t - 1 - mon_last, e.len);
                    check("period_high", mon_acc, e.hi);
                    $display("period %s: len %0d high %0d", cur_name, mon_t - 1 - mon_last, mon_acc);
                end
                mon_last = mon_t - 1;
                mon_acc  = 0;
            end
            mon_prev_stb = bus.o_period_stb;
            mon_t++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int len, input int hi);
        exp_t e;
        e.len = len;
        e.hi  = hi;
        sb_q.push_back(e);
    endtask

    // Holds reset for a few clocks, checks reset outputs, releases just after an edge.
    task automatic do_reset();
        rst = 1'b1;
        cyc(3);
        check("rst_pwm", int'(bus.o_pwm), 0);
        check("rst_level", int'(bus.o_level), 0);
        check("rst_stb", int'(bus.o_period_stb), 0);
        rst = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int k = 0;
        while (sb_q.size() > 0 && k < max_cyc) begin
            cyc(1);
            k++;
        end
        if (sb_q.size() > 0) begin
            check("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    task automatic set_inputs(input logic [PHASE_W-1:0] delta, input logic [ENV_W-1:0] env,
                              input logic [1:0] duty);
        bus.i_phase_delta = delta;
        bus.i_envelope    = env;
        bus.i_duty        = duty_e'(duty);
    endtask

    task automatic pulse_top(input logic [TOP_W-1:0] top);
        bus.i_top       = top;
        bus.i_top_valid = 1'b1;
        cyc(1);
        bus.i_top_valid = 1'b0;
    endtask

    vec_t tbl[18];

    initial begin
        bus.i_top         = '0;
        bus.i_top_valid   = 1'b0;
        bus.i_phase_delta = '0;
        bus.i_envelope    = '0;
        bus.i_duty        = DUTY_12;

        //          top     delta          env     duty  len  hi2  hi3  lvl2
        tbl[0]  = '{8'd255, 32'h0000_0000, 9'd30,  2'd2, 256, 0,   0,   0};
        tbl[1]  = '{8'd15,  32'h0000_0001, 9'd5,   2'd0, 16,  5,   5,   5};
        tbl[2]  = '{8'd20,  32'h0000_0001, 9'd100, 2'd3, 21,  21,  21,  100};
        tbl[3]  = '{8'd9,   32'hFFFF_FFFF, 9'd200, 2'd3, 10,  0,   0,   0};
        tbl[4]  = '{8'd0,   32'h0000_0001, 9'd1,   2'd1, 1,   1,   1,   1};
        tbl[5]  = '{8'd7,   32'h0000_0001, 9'd0,   2'd2, 8,   0,   0,   0};
        tbl[6]  = '{8'd255, 32'h0000_0001, 9'd255, 2'd1, 256, 255, 255, 255};
        tbl[7]  = '{8'd255, 32'h0000_0001, 9'd256, 2'd1, 256, 256, 256, 256};
        tbl[8]  = '{8'd3,   32'h0000_0001, 9'd4,   2'd0, 4,   4,   4,   4};
        tbl[9]  = '{8'd3,   32'h0000_0001, 9'd3,   2'd0, 4,   3,   3,   3};
        tbl[10] = '{8'd8,   32'h2000_0000, 9'd5,   2'd0, 9,   0,   5,   0};
        tbl[11] = '{8'd9,   32'h2000_0000, 9'd5,   2'd0, 10,  0,   0,   0};
        tbl[12] = '{8'd17,  32'h2000_0000, 9'd5,   2'd1, 18,  0,   5,   0};
        tbl[13] = '{8'd18,  32'h2000_0000, 9'd5,   2'd1, 19,  0,   0,   0};
        tbl[14] = '{8'd11,  32'h2000_0000, 9'd5,   2'd2, 12,  0,   5,   0};
        tbl[15] = '{8'd12,  32'h2000_0000, 9'd5,   2'd2, 13,  0,   0,   0};
        tbl[16] = '{8'd13,  32'h2000_0000, 9'd5,   2'd3, 14,  0,   5,   0};
        tbl[17] = '{8'd14,  32'h2000_0000, 9'd5,   2'd3, 15,  0,   0,   0};

        cyc(1);
        for (int i = 0; i < 18; i++) begin
            cur_name = $sformatf("vec%0d", i);
            set_inputs(tbl[i].delta, tbl[i].env, tbl[i].duty);
            do_reset();
            push(256, 0);
            push(tbl[i].len, tbl[i].hi2);
            push(tbl[i].len, tbl[i].hi3);
            cyc(10);
            pulse_top(tbl[i].top);
            cyc(246);
            check("level_after_wrap", int'(bus.o_level), tbl[i].lvl2);
            drain(2000);
        end

        // Request on the wrap cycle beats an earlier pending request.
        cur_name = "wrap_beats_pend";
        set_inputs(32'd1, 9'd4, 2'd0);
        do_reset();
        push(256, 0);
        push(10, 4);
        push(10, 4);
        cyc(10);
        pulse_top(8'd50);
        cyc(244);
        check("stb_at_255", int'(bus.o_period_stb), 1);
        pulse_top(8'd9);
        drain(2000);

        // Two requests in one period: the later one wins.
        cur_name = "last_wins";
        set_inputs(32'd1, 9'd40, 2'd0);
        do_reset();
        push(256, 0);
        push(31, 31);
        push(31, 31);
        cyc(10);
        pulse_top(8'd50);
        cyc(9);
        pulse_top(8'd30);
        drain(2000);

        // top_valid held high; envelope change mid-period waits for the wrap.
        cur_name = "held_valid_env_change";
        set_inputs(32'd1, 9'd10, 2'd0);
        bus.i_top       = 8'd15;
        bus.i_top_valid = 1'b1;
        do_reset();
        push(256, 0);
        push(16, 10);
        push(16, 3);
        cyc(260);
        bus.i_envelope = 9'd3;
        cyc(5);
        check("level_held", int'(bus.o_level), 10);
        drain(2000);
        bus.i_top_valid = 1'b0;

        // Reset at cnt=100 with a pending top discards the pending value.
        cur_name = "reset_mid_period";
        set_inputs(32'd1, 9'd300, 2'd0);
        do_reset();
        cyc(300);
        pulse_top(8'd40);
        cyc(55);
        check("pwm_before_rst", int'(bus.o_pwm), 1);
        check("level_before_rst", int'(bus.o_level), 300);
        #2;
        rst = 1'b1;
        #1;
        check("pwm_async_rst", int'(bus.o_pwm), 0);
        check("level_async_rst", int'(bus.o_level), 0);
        check("stb_async_rst", int'(bus.o_period_stb), 0);
        cyc(2);
        rst = 1'b0;
        push(256, 0);
        push(256, 256);
        push(256, 256);
        drain(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
